// File: rtl/ngp_pkg.sv
// Shared NGP arbiter constants and types: default widths, requester indices, requester id type.
// Pure declarations; no timing or flow control.
// Backpressure: not applicable.
package ngp_pkg;

    localparam int NGP_ADDR_W   = 16;
    localparam int NGP_DATA_W   = 16;
    localparam int NGP_NREQ_MAX = 4;

    localparam int REQ_DATA  = 0;
    localparam int REQ_FETCH = 1;
    localparam int REQ_LOAD  = 2;

    // Sized for the largest supported requester count so the id type is package-global.
    typedef logic [$clog2(NGP_NREQ_MAX)-1:0] req_id_t;

endpackage

// File: rtl/ngp_rr_pick.sv
// Round-robin picker: first valid bit at or above start, wrapping modulo N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller masks valid as needed.
import ngp_pkg::*;

module ngp_rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] valid,
    input  req_id_t      start,
    output logic [N-1:0] grant,
    output req_id_t      id,
    output logic         any
);

    int idx;

    // Scan from the farthest offset down so the nearest valid requester wins last.
    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            if (valid[idx]) begin
                any = 1'b1;
                id  = req_id_t'(idx);
            end
        end
        if (any) begin
            grant = {{(N-1){1'b0}}, 1'b1} << id;
        end
    end

endmodule

// File: rtl/ngp_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NREQ requesters; optional grant lock via NGP_ARB_LOCK_EN.
// Latency: grant and memory strobe same cycle; read response exactly MEM_LAT cycles after grant.
// Backpressure: req_ready is the one-hot grant; responses cannot be stalled.
import ngp_pkg::*;

module ngp_mem_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = NGP_ADDR_W,
    parameter int DATA_W  = NGP_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    grant;
    req_id_t            gid;
    req_id_t            rr_ptr;
    logic               gany;
    logic               granted;
    logic [MEM_LAT-1:0] pipe_vld;
    req_id_t            pipe_id [MEM_LAT];

`ifdef NGP_ARB_LOCK_EN
    logic    lock_valid;
    req_id_t lock_id;

    // A held lock masks everyone else, even while the holder is idle.
    always_comb begin
        elig = req_valid;
        if (lock_valid) begin
            elig = req_valid & ({{(NREQ-1){1'b0}}, 1'b1} << lock_id);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_valid <= 1'b0;
            lock_id    <= '0;
        end else if (granted) begin
            lock_valid <= req_lock[gid];
            if (req_lock[gid]) begin
                lock_id <= gid;
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign elig        = req_valid;
`endif

    ngp_rr_pick #(.N(NREQ)) u_pick (
        .valid (elig),
        .start (rr_ptr),
        .grant (grant),
        .id    (gid),
        .any   (gany)
    );

    assign granted   = gany & ~rst;
    assign req_ready = granted ? grant : '0;
    assign rsp_rdata = mem_rdata;

    always_comb begin
        mem_en    = granted;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (granted) begin
            mem_we    = req_we[gid];
            mem_addr  = req_addr[gid*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[gid*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (granted) begin
            rr_ptr <= (gid == req_id_t'(NREQ - 1)) ? '0 : gid + req_id_t'(1);
        end
    end

    // Only reads enter the pipe; the last stage lines up with mem_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= granted & ~req_we[gid];
            pipe_id[0]  <= gid;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (pipe_vld[MEM_LAT-1] && !rst) begin
            rsp_valid = {{(NREQ-1){1'b0}}, 1'b1} << pipe_id[MEM_LAT-1];
        end
    end

endmodule

// File: tb/tb_ngp_mem_arbiter.sv
// Bench for ngp_mem_arbiter: two instances (MEM_LAT 1 and 2) share one stimulus stream,
// checked by directed tables, corner sequences and a random run against a queue-based model.
module tb_ngp_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  valid, we, lock;
    logic [47:0] addr, wdata;

    logic [2:0]  ready [2];
    logic [2:0]  rspv  [2];
    logic [15:0] rdata [2];
    logic        men   [2];
    logic        mwe   [2];
    logic [15:0] maddr [2];
    logic [15:0] mwdat [2];
    logic [15:0] mrdat [2];

    ngp_mem_arbiter #(.NREQ(3), .ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(valid), .req_ready(ready[0]), .req_we(we),
        .req_lock(lock), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rspv[0]),
        .rsp_rdata(rdata[0]), .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]),
        .mem_wdata(mwdat[0]), .mem_rdata(mrdat[0]));

    ngp_mem_arbiter #(.NREQ(3), .ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(valid), .req_ready(ready[1]), .req_we(we),
        .req_lock(lock), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rspv[1]),
        .rsp_rdata(rdata[1]), .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]),
        .mem_wdata(mwdat[1]), .mem_rdata(mrdat[1]));

    // Environment memory, 256 words, with per-instance read delay lines.
    logic [15:0] mem [256];
    logic        init_mem;
    logic [15:0] dl1, dl2a, dl2b;

    function automatic logic [15:0] fill(int i);
        if (i == 16) return 16'hBEEF;
        if (i == 1)  return 16'hA001;
        if (i == 2)  return 16'hA002;
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= fill(i);
        end else if (men[0] && mwe[0]) begin
            mem[maddr[0][7:0]] <= mwdat[0];
        end
        if (men[0] && !mwe[0]) dl1 <= mem[maddr[0][7:0]];
        if (men[1] && !mwe[1]) dl2a <= mem[maddr[1][7:0]];
        dl2b <= dl2a;
    end

    always_comb begin
        mrdat[0] = dl1;
        mrdat[1] = dl2b;
    end

    // Reference model state.
    typedef struct { int due; int id; logic [15:0] data; } rsp_t;
    rsp_t pend [2][$];
    int   rr, cyc, lk_v, lk_id;
    int   nvec, nerr;

    logic [2:0]  obs_ready, obs_rsp [2];
    logic [15:0] obs_addr, obs_wd, obs_rdata [2];
    logic        obs_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick();
        int m;
        m = int'(valid);
`ifdef NGP_ARB_LOCK_EN
        if (lk_v != 0) m = m & (1 << lk_id);
`endif
        for (int k = 0; k < 3; k++) begin
            if (m[(rr + k) % 3]) return (rr + k) % 3;
        end
        return -1;
    endfunction

    // Check this cycle's outputs against the model, then advance one clock.
    task automatic step();
        int g;
        logic [2:0]  er, erv;
        logic [15:0] ea, ew;
        logic        ewe;
        #3;
        g   = rst ? -1 : pick();
        er  = (g >= 0) ? 3'(1 << g) : 3'b000;
        ea  = (g >= 0) ? addr[g*16 +: 16] : 16'h0;
        ew  = (g >= 0) ? wdata[g*16 +: 16] : 16'h0;
        ewe = (g >= 0) ? we[g] : 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready%0d", d), 32'(ready[d]), 32'(er));
            chk($sformatf("mem_en%0d", d), 32'(men[d]), 32'(g >= 0));
            chk($sformatf("mem_we%0d", d), 32'(mwe[d]), 32'(ewe));
            chk($sformatf("mem_addr%0d", d), 32'(maddr[d]), 32'(ea));
            chk($sformatf("mem_wdata%0d", d), 32'(mwdat[d]), 32'(ew));
            erv = 3'b000;
            if (!rst && pend[d].size() > 0 && pend[d][0].due == cyc) begin
                erv = 3'(1 << pend[d][0].id);
                chk($sformatf("rsp_rdata%0d", d), 32'(rdata[d]), 32'(pend[d][0].data));
                void'(pend[d].pop_front());
            end
            chk($sformatf("rsp_valid%0d", d), 32'(rspv[d]), 32'(erv));
            obs_rsp[d]   = rspv[d];
            obs_rdata[d] = rdata[d];
        end
        obs_ready = ready[0];
        obs_addr  = maddr[0];
        obs_wd    = mwdat[0];
        obs_we    = mwe[0];
        if (rst) begin
            pend[0].delete();
            pend[1].delete();
            rr   = 0;
            lk_v = 0;
        end else if (g >= 0) begin
            if (!we[g]) begin
                for (int d = 0; d < 2; d++) begin
                    pend[d].push_back('{due: cyc + d + 1, id: g, data: mem[addr[g*16 +: 8]]});
                end
            end
            rr = (g + 1) % 3;
            lk_v = lock[g] ? 1 : 0;
            if (lock[g]) lk_id = g;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  v, w;
        logic [47:0] a, wd;
        logic [2:0]  e_rdy;
        logic [15:0] e_addr;
        logic        e_we;
        logic [15:0] e_wd;
        logic [2:0]  e_rsp1, e_rsp2;
    } vec_t;

    vec_t tbl [13];
    localparam logic [47:0] A_ALL = {16'h0030, 16'h0020, 16'h0010};
    localparam logic [47:0] A_WR  = {16'h00FF, 16'h0020, 16'h0010};
    localparam logic [47:0] D_WR  = {16'h1234, 16'h0000, 16'h0000};

    int gseq [6];
    int gexp [6];
    int beat;

    initial begin
        nvec = 0; nerr = 0; cyc = 0; rr = 0; lk_v = 0; lk_id = 0;
        valid = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        init_mem = 1'b1;
        do_reset();
        init_mem = 1'b0;

        tbl[0]  = '{3'b001, 3'b000, A_ALL, 48'h0, 3'b001, 16'h0010, 1'b0, 16'h0,    3'b000, 3'b000};
        tbl[1]  = '{3'b000, 3'b000, A_ALL, 48'h0, 3'b000, 16'h0000, 1'b0, 16'h0,    3'b001, 3'b000};
        tbl[2]  = '{3'b000, 3'b000, A_ALL, 48'h0, 3'b000, 16'h0000, 1'b0, 16'h0,    3'b000, 3'b001};
        tbl[3]  = '{3'b100, 3'b100, A_WR,  D_WR,  3'b100, 16'h00FF, 1'b1, 16'h1234, 3'b000, 3'b000};
        tbl[4]  = '{3'b000, 3'b000, A_ALL, 48'h0, 3'b000, 16'h0000, 1'b0, 16'h0,    3'b000, 3'b000};
        tbl[5]  = '{3'b111, 3'b000, A_ALL, 48'h0, 3'b001, 16'h0010, 1'b0, 16'h0,    3'b000, 3'b000};
        tbl[6]  = '{3'b111, 3'b000, A_ALL, 48'h0, 3'b010, 16'h0020, 1'b0, 16'h0,    3'b001, 3'b000};
        tbl[7]  = '{3'b111, 3'b000, A_ALL, 48'h0, 3'b100, 16'h0030, 1'b0, 16'h0,    3'b010, 3'b001};
        tbl[8]  = '{3'b111, 3'b000, A_ALL, 48'h0, 3'b001, 16'h0010, 1'b0, 16'h0,    3'b100, 3'b010};
        tbl[9]  = '{3'b111, 3'b000, A_ALL, 48'h0, 3'b010, 16'h0020, 1'b0, 16'h0,    3'b001, 3'b100};
        tbl[10] = '{3'b111, 3'b000, A_ALL, 48'h0, 3'b100, 16'h0030, 1'b0, 16'h0,    3'b010, 3'b001};
        tbl[11] = '{3'b000, 3'b000, A_ALL, 48'h0, 3'b000, 16'h0000, 1'b0, 16'h0,    3'b100, 3'b010};
        tbl[12] = '{3'b000, 3'b000, A_ALL, 48'h0, 3'b000, 16'h0000, 1'b0, 16'h0,    3'b000, 3'b100};

        for (int i = 0; i < 13; i++) begin
            valid = tbl[i].v; we = tbl[i].w; addr = tbl[i].a; wdata = tbl[i].wd; lock = '0;
            step();
            chk($sformatf("tbl%0d_ready", i), 32'(obs_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_addr", i), 32'(obs_addr), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_we", i), 32'(obs_we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_wdata", i), 32'(obs_wd), 32'(tbl[i].e_wd));
            chk($sformatf("tbl%0d_rsp1", i), 32'(obs_rsp[0]), 32'(tbl[i].e_rsp1));
            chk($sformatf("tbl%0d_rsp2", i), 32'(obs_rsp[1]), 32'(tbl[i].e_rsp2));
            if (i == 1) chk("tbl1_rdata_beef", 32'(obs_rdata[0]), 32'h0000BEEF);
        end

        // Back-to-back reads from requester 1 on the two-cycle instance.
        do_reset();
        we = '0; wdata = '0;
        valid = 3'b010; addr = {16'h0, 16'h0001, 16'h0};
        step();
        addr = {16'h0, 16'h0002, 16'h0};
        step();
        valid = '0;
        step();
        chk("b2b_rsp_first", 32'(obs_rsp[1]), 32'b010);
        chk("b2b_data_first", 32'(obs_rdata[1]), 32'hA001);
        step();
        chk("b2b_rsp_second", 32'(obs_rsp[1]), 32'b010);
        chk("b2b_data_second", 32'(obs_rdata[1]), 32'hA002);

        // Reset while a two-cycle read is in flight.
        do_reset();
        valid = 3'b010; addr = {16'h0, 16'h0001, 16'h0};
        step();
        rst = 1'b1; valid = '0;
        step();
        rst = 1'b0;
        step();
        chk("rstflight_rsp_a", 32'(obs_rsp[1]), 32'b000);
        step();
        chk("rstflight_rsp_b", 32'(obs_rsp[1]), 32'b000);
        valid = 3'b011;
        step();
        chk("rstflight_prio0", 32'(obs_ready), 32'b001);

        // Requester 0 issues three beats with lock 1,1,0 against a busy requester 1.
        do_reset();
        valid = '0; we = '0; addr = A_ALL;
        beat = 0;
        for (int c = 0; c < 6; c++) begin
            valid = {1'b0, 1'b1, (beat < 3)};
            lock  = {2'b00, (beat < 2)};
            step();
            gseq[c] = obs_ready[0] ? 0 : (obs_ready[1] ? 1 : (obs_ready[2] ? 2 : -1));
            if (obs_ready[0]) beat++;
        end
`ifdef NGP_ARB_LOCK_EN
        gexp = '{0, 0, 0, 1, 1, 1};
`else
        gexp = '{0, 1, 0, 1, 0, 1};
`endif
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("lock_seq%0d", c), 32'(gseq[c]), 32'(gexp[c]));
        end
        lock = '0;

        // Random traffic; a pending requester holds its command until accepted.
        do_reset();
        valid = '0;
        obs_ready = '0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 3; i++) begin
                if (!valid[i] || obs_ready[i]) begin
                    we[i]             = ($urandom_range(0, 2) == 0);
                    lock[i]           = ($urandom_range(0, 3) == 0);
                    addr[i*16 +: 16]  = 16'($urandom_range(0, 255));
                    wdata[i*16 +: 16] = 16'($urandom);
                end
                valid[i] = ($urandom_range(0, 9) < 7);
            end
            step();
        end
        rst = 1'b0; valid = '0;
        for (int c = 0; c < 3; c++) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
